// File: rtl/ball_controller.sv
// Pong ball: serve delay, once-per-frame motion, wall/paddle reflection and goal detection.
// Sprite field widths live in ball_pkg so the collision checkers share the same layout.
package ball_pkg;
    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 9;

    typedef struct packed {
        logic [X_POS_W-1:0] x_pos;
        logic [Y_POS_W-1:0] y_pos;
        logic [X_POS_W-1:0] right;
        logic [Y_POS_W-1:0] bottom;
    } sprite_t;
endpackage

module ball_controller
    import ball_pkg::*;
#(
    parameter int SCREEN_W       = 640,
    parameter int SCREEN_H       = 480,
    parameter int BALL_SIZE      = 8,
    parameter int SPEED_X        = 2,
    parameter int SPEED_Y        = 1,
    parameter int SERVE_FRAMES   = 60,
    parameter int HOLDOFF_FRAMES = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    frame_tick_i,
    input  logic    collision_l_i,
    input  logic    collision_r_i,
    output sprite_t ball_o,
    output logic    score_l_o,
    output logic    score_r_o,
    output logic    in_play_o
);
    localparam int SERVE_W = $clog2(SERVE_FRAMES + 1);
    localparam int HOLD_W  = $clog2(HOLDOFF_FRAMES + 1);

    localparam logic [X_POS_W-1:0] X_CENTRE = X_POS_W'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [Y_POS_W-1:0] Y_CENTRE = Y_POS_W'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [X_POS_W-1:0] X_SIZE   = X_POS_W'(BALL_SIZE);
    localparam logic [Y_POS_W-1:0] Y_SIZE   = Y_POS_W'(BALL_SIZE);
    localparam logic [X_POS_W-1:0] X_STEP   = X_POS_W'(SPEED_X);
    localparam logic [Y_POS_W-1:0] Y_STEP   = Y_POS_W'(SPEED_Y);
    localparam logic [X_POS_W:0]   X_LIMIT  = (X_POS_W+1)'(SCREEN_W - BALL_SIZE);
    localparam logic [Y_POS_W:0]   Y_LIMIT  = (Y_POS_W+1)'(SCREEN_H - BALL_SIZE);
    localparam logic [Y_POS_W-1:0] Y_FLOOR  = Y_POS_W'(SCREEN_H - BALL_SIZE);
    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_FRAMES - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLDOFF_FRAMES);

    typedef enum logic [1:0] {SERVE, PLAY, GOAL} state_t;

    state_t             state;
    logic [SERVE_W-1:0] serve_cnt;
    logic [HOLD_W-1:0]  holdoff;
    logic               dir_x;      // 1 = right
    logic               dir_y;      // 1 = down
    logic               hit_l, hit_r;

    logic               hold_active, bounce_l, bounce_r, dir_x_nxt;
    logic               goal_l, goal_r, wall_top, wall_bot;
    logic [X_POS_W-1:0] x_step_nxt;
    logic [Y_POS_W-1:0] y_step_nxt;

    // Next-frame motion from pre-tick values; widened compares keep x/y from wrapping.
    always_comb begin
        hold_active = (holdoff != '0);
        bounce_l    = !hold_active && hit_l && !dir_x;
        bounce_r    = !hold_active && hit_r && dir_x;
        dir_x_nxt   = bounce_l ? 1'b1 : (bounce_r ? 1'b0 : dir_x);

        goal_r      = !dir_x_nxt && (ball_o.x_pos < X_STEP);
        goal_l      = dir_x_nxt && (({1'b0, ball_o.x_pos} + {1'b0, X_STEP}) > X_LIMIT);
        x_step_nxt  = dir_x_nxt ? ball_o.x_pos + X_STEP : ball_o.x_pos - X_STEP;

        wall_top    = !dir_y && (ball_o.y_pos < Y_STEP);
        wall_bot    = dir_y && (({1'b0, ball_o.y_pos} + {1'b0, Y_STEP}) > Y_LIMIT);
        y_step_nxt  = dir_y ? ball_o.y_pos + Y_STEP : ball_o.y_pos - Y_STEP;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= SERVE;
            serve_cnt     <= '0;
            holdoff       <= '0;
            dir_x         <= 1'b1;
            dir_y         <= 1'b1;
            hit_l         <= 1'b0;
            hit_r         <= 1'b0;
            ball_o.x_pos  <= X_CENTRE;
            ball_o.y_pos  <= Y_CENTRE;
            ball_o.right  <= X_CENTRE + X_SIZE;
            ball_o.bottom <= Y_CENTRE + Y_SIZE;
            score_l_o     <= 1'b0;
            score_r_o     <= 1'b0;
            in_play_o     <= 1'b0;
        end else begin
            score_l_o <= 1'b0;
            score_r_o <= 1'b0;
            // A collision coinciding with the tick belongs to no frame and is dropped.
            hit_l <= frame_tick_i ? 1'b0 : (hit_l | collision_l_i);
            hit_r <= frame_tick_i ? 1'b0 : (hit_r | collision_r_i);

            case (state)
                SERVE: begin
                    if (frame_tick_i) begin
                        if (serve_cnt == SERVE_LAST) begin
                            serve_cnt <= '0;
                            state     <= PLAY;
                            in_play_o <= 1'b1;
                        end else begin
                            serve_cnt <= serve_cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (frame_tick_i) begin
                        if (hold_active)
                            holdoff <= holdoff - 1'b1;
                        else if (bounce_l || bounce_r)
                            holdoff <= HOLD_LOAD;
                        dir_x <= dir_x_nxt;

                        if (wall_top) begin
                            ball_o.y_pos  <= '0;
                            ball_o.bottom <= Y_SIZE;
                            dir_y         <= 1'b1;
                        end else if (wall_bot) begin
                            ball_o.y_pos  <= Y_FLOOR;
                            ball_o.bottom <= Y_FLOOR + Y_SIZE;
                            dir_y         <= 1'b0;
                        end else begin
                            ball_o.y_pos  <= y_step_nxt;
                            ball_o.bottom <= y_step_nxt + Y_SIZE;
                        end

                        if (goal_r) begin
                            score_r_o <= 1'b1;
                            state     <= GOAL;
                            in_play_o <= 1'b0;
                        end else if (goal_l) begin
                            score_l_o <= 1'b1;
                            state     <= GOAL;
                            in_play_o <= 1'b0;
                        end else begin
                            ball_o.x_pos <= x_step_nxt;
                            ball_o.right <= x_step_nxt + X_SIZE;
                        end
                    end
                end
                GOAL: begin
                    // Serve toward the player who conceded; ticks are ignored here.
                    ball_o.x_pos  <= X_CENTRE;
                    ball_o.y_pos  <= Y_CENTRE;
                    ball_o.right  <= X_CENTRE + X_SIZE;
                    ball_o.bottom <= Y_CENTRE + Y_SIZE;
                    serve_cnt     <= '0;
                    holdoff       <= '0;
                    dir_x         <= score_l_o;
                    state         <= SERVE;
                end
                default: begin
                    state     <= SERVE;
                    in_play_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_controller.sv
// Bench for ball_controller: directed scenarios plus randomized play against an integer reference model.
module tb_ball_controller;
    import ball_pkg::*;

    logic    clk_i = 1'b0;
    logic    rst_i = 1'b1;
    logic    frame_tick_i = 1'b0;
    logic    collision_l_i = 1'b0;
    logic    collision_r_i = 1'b0;
    sprite_t ball_o;
    logic    score_l_o, score_r_o, in_play_o;

    ball_controller dut (
        .clk_i(clk_i), .rst_i(rst_i), .frame_tick_i(frame_tick_i),
        .collision_l_i(collision_l_i), .collision_r_i(collision_r_i),
        .ball_o(ball_o), .score_l_o(score_l_o), .score_r_o(score_r_o), .in_play_o(in_play_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: signed ints, directions as +1/-1, phase 0=serve 1=play 2=goal.
    int m_x, m_y, m_dx, m_dy, m_st, m_sv, m_hd;
    bit m_hl, m_hr, m_sl, m_sr, m_ip;

    always @(posedge clk_i) begin : ref_model
        int x, y, dx, dy, st, sv, hd;
        bit hl, hr, sl, sr;
        x = m_x; y = m_y; dx = m_dx; dy = m_dy; st = m_st; sv = m_sv; hd = m_hd;
        hl = m_hl; hr = m_hr; sl = 0; sr = 0;
        if (rst_i) begin
            x = 316; y = 236; dx = 1; dy = 1; st = 0; sv = 0; hd = 0; hl = 0; hr = 0;
        end else begin
            case (st)
                0: if (frame_tick_i) begin
                    if (sv == 59) begin sv = 0; st = 1; end
                    else sv = sv + 1;
                end
                1: if (frame_tick_i) begin
                    if (hd > 0) hd = hd - 1;
                    else if (m_hl && dx < 0) begin dx = 1; hd = 4; end
                    else if (m_hr && dx > 0) begin dx = -1; hd = 4; end
                    if (y + dy < 0) begin y = 0; dy = 1; end
                    else if (y + dy > 472) begin y = 472; dy = -1; end
                    else y = y + dy;
                    if (x + 2 * dx < 0) begin sr = 1; st = 2; end
                    else if (x + 2 * dx > 632) begin sl = 1; st = 2; end
                    else x = x + 2 * dx;
                end
                default: begin
                    x = 316; y = 236; sv = 0; hd = 0; st = 0;
                    dx = m_sr ? -1 : 1;
                end
            endcase
            hl = frame_tick_i ? 1'b0 : (m_hl | collision_l_i);
            hr = frame_tick_i ? 1'b0 : (m_hr | collision_r_i);
        end
        m_x <= x; m_y <= y; m_dx <= dx; m_dy <= dy; m_st <= st; m_sv <= sv; m_hd <= hd;
        m_hl <= hl; m_hr <= hr; m_sl <= sl; m_sr <= sr; m_ip <= (st == 1);
    end

    logic [40:0] dut_vec;
    assign dut_vec = {ball_o.x_pos, ball_o.y_pos, ball_o.right, ball_o.bottom,
                      score_l_o, score_r_o, in_play_o};

    function automatic logic [40:0] exp_vec();
        return {10'(m_x), 9'(m_y), 10'(m_x + 8), 9'(m_y + 8), m_sl, m_sr, m_ip};
    endfunction

    // One clock: drive at the falling edge, return at the next falling edge.
    task automatic cyc(input logic tk, input logic cl, input logic cr);
        frame_tick_i = tk; collision_l_i = cl; collision_r_i = cr;
        @(negedge clk_i);
    endtask

    task automatic frm(input logic cl, input logic cr);
        repeat (3) cyc(1'b0, cl, cr);
        cyc(1'b1, 1'b0, 1'b0);
    endtask

    // Paddles that always return the ball: keeps a rally going indefinitely.
    task automatic auto_frm();
        frm(m_dx < 0 && m_x <= 6, m_dx > 0 && m_x >= 626);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        n_cmp++;
        if (dut_vec !== {10'd316, 9'd236, 10'd324, 9'd244, 3'b000}) begin
            n_bad++; $display("FAIL reset: got %h want %h", dut_vec, {10'd316, 9'd236, 10'd324, 9'd244, 3'b000});
        end
    endtask

    task automatic test_serve();
        for (int i = 0; i < 59; i++) frm(1'b0, 1'b0);
        n_cmp++;
        if ({ball_o.x_pos, ball_o.y_pos, in_play_o} !== {10'd316, 9'd236, 1'b0}) begin
            n_bad++; $display("FAIL serve_59: got x=%0d y=%0d play=%b want 316 236 0", ball_o.x_pos, ball_o.y_pos, in_play_o);
        end
        frm(1'b0, 1'b0);
        n_cmp++;
        if (in_play_o !== 1'b1) begin
            n_bad++; $display("FAIL serve_60: got play=%b want 1", in_play_o);
        end
        frm(1'b0, 1'b0);
        n_cmp++;
        if ({ball_o.x_pos, ball_o.y_pos, ball_o.right, ball_o.bottom} !== {10'd318, 9'd237, 10'd326, 9'd245}) begin
            n_bad++; $display("FAIL first_move: got x=%0d y=%0d want 318 237", ball_o.x_pos, ball_o.y_pos);
        end
    endtask

    task automatic test_paddle();
        frm(1'b0, 1'b1);
        n_cmp++;
        if (ball_o.x_pos !== 10'd316) begin
            n_bad++; $display("FAIL bounce_r: got x=%0d want 316", ball_o.x_pos);
        end
        // Left hits during the holdoff must not turn the ball around.
        for (int i = 1; i <= 4; i++) begin
            frm(1'b1, 1'b0);
            n_cmp++;
            if (ball_o.x_pos !== 10'(316 - 2 * i)) begin
                n_bad++; $display("FAIL holdoff_%0d: got x=%0d want %0d", i, ball_o.x_pos, 316 - 2 * i);
            end
        end
        frm(1'b1, 1'b0);
        n_cmp++;
        if (ball_o.x_pos !== 10'd310) begin
            n_bad++; $display("FAIL holdoff_expired: got x=%0d want 310", ball_o.x_pos);
        end
    endtask

    task automatic test_back_to_back();
        repeat (4) frm(1'b0, 1'b0);
        frm(1'b0, 1'b1);
        repeat (4) frm(1'b0, 1'b0);
        n_cmp++;
        if (ball_o.x_pos !== 10'd308) begin
            n_bad++; $display("FAIL setup_left: got x=%0d want 308", ball_o.x_pos);
        end
        frm(1'b1, 1'b1);
        n_cmp++;
        if (ball_o.x_pos !== 10'd310) begin
            n_bad++; $display("FAIL both_hits: got x=%0d want 310", ball_o.x_pos);
        end
        repeat (4) frm(1'b0, 1'b0);
        frm(1'b0, 1'b1);
        repeat (4) frm(1'b0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (ball_o.x_pos !== 10'd306) begin
            n_bad++; $display("FAIL tick_cycle_hit: got x=%0d want 306", ball_o.x_pos);
        end
        frm(1'b0, 1'b0);
        n_cmp++;
        if (dut_vec !== exp_vec() || ball_o.x_pos !== 10'd304) begin
            n_bad++; $display("FAIL hit_dropped: got %h want %h (x 304)", dut_vec, exp_vec());
        end
    endtask

    task automatic test_walls();
        int k;
        k = 0;
        while (!(m_y == 471 && m_dy == 1 && m_st == 1) && k < 1200) begin auto_frm(); k++; end
        n_cmp++;
        if (k >= 1200) begin
            n_bad++; $display("FAIL walls_bottom_timeout: got y=%0d want 471", ball_o.y_pos);
        end
        for (int i = 0; i < 3; i++) begin
            auto_frm();
            n_cmp++;
            if (ball_o.y_pos !== 9'(i < 2 ? 472 : 471) || dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL wall_bottom_%0d: got y=%0d want %0d", i, ball_o.y_pos, i < 2 ? 472 : 471);
            end
        end
        k = 0;
        while (!(m_y == 1 && m_dy == -1 && m_st == 1) && k < 1200) begin auto_frm(); k++; end
        n_cmp++;
        if (k >= 1200) begin
            n_bad++; $display("FAIL walls_top_timeout: got y=%0d want 1", ball_o.y_pos);
        end
        for (int i = 0; i < 3; i++) begin
            auto_frm();
            n_cmp++;
            if (ball_o.y_pos !== 9'(i < 2 ? 0 : 1) || dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL wall_top_%0d: got y=%0d want %0d", i, ball_o.y_pos, i < 2 ? 0 : 1);
            end
        end
    endtask

    task automatic test_goal();
        int k;
        k = 0;
        // Only the right paddle returns the ball, so it leaves on the left side.
        while (m_st != 2 && k < 800) begin
            frm(1'b0, m_dx > 0 && m_x >= 626);
            k++;
        end
        n_cmp++;
        if (k >= 800 || {score_l_o, score_r_o} !== 2'b01) begin
            n_bad++; $display("FAIL goal_pulse: got l=%b r=%b want 0 1", score_l_o, score_r_o);
        end
        cyc(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (dut_vec !== {10'd316, 9'd236, 10'd324, 9'd244, 3'b000}) begin
            n_bad++; $display("FAIL goal_recentre: got %h want %h", dut_vec, {10'd316, 9'd236, 10'd324, 9'd244, 3'b000});
        end
        for (int i = 0; i < 59; i++) frm(1'b0, 1'b0);
        n_cmp++;
        if (in_play_o !== 1'b0) begin
            n_bad++; $display("FAIL reserve_59: got play=%b want 0", in_play_o);
        end
        frm(1'b0, 1'b0);
        frm(1'b0, 1'b0);
        n_cmp++;
        if ({in_play_o, ball_o.x_pos} !== {1'b1, 10'd314}) begin
            n_bad++; $display("FAIL reserve_dir: got play=%b x=%0d want 1 314", in_play_o, ball_o.x_pos);
        end
    endtask

    task automatic test_reset_mid_play();
        int k;
        k = 0;
        while (!(m_x == 500 && m_st == 1) && k < 1000) begin auto_frm(); k++; end
        n_cmp++;
        if (k >= 1000) begin
            n_bad++; $display("FAIL reach_500_timeout: got x=%0d want 500", ball_o.x_pos);
        end
        rst_i = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        rst_i = 1'b0;
        n_cmp++;
        if (dut_vec !== {10'd316, 9'd236, 10'd324, 9'd244, 3'b000}) begin
            n_bad++; $display("FAIL reset_mid_play: got %h want %h", dut_vec, {10'd316, 9'd236, 10'd324, 9'd244, 3'b000});
        end
    endtask

    task automatic test_random();
        logic tk, cl, cr;
        for (int i = 0; i < 8000; i++) begin
            tk = ($urandom_range(0, 3) == 0);
            cl = (m_dx < 0 && m_x <= 6 && $urandom_range(0, 9) != 0) || ($urandom_range(0, 19) == 0);
            cr = (m_dx > 0 && m_x >= 626 && $urandom_range(0, 9) != 0) || ($urandom_range(0, 19) == 0);
            rst_i = ($urandom_range(0, 2999) == 0);
            cyc(tk, cl, cr);
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_bad++; $display("FAIL random_cyc_%0d: got %h want %h", i, dut_vec, exp_vec());
            end
        end
        rst_i = 1'b0;
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_serve();
        test_paddle();
        test_back_to_back();
        test_walls();
        test_goal();
        test_reset_mid_play();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_controller.md
Name: ball_controller

Overview:
- Produces the ball sprite consumed by the two sprite_collision instances (ball vs left paddle, ball vs right paddle) and acts on their collision_o outputs.
- Advances the ball once per frame, reflects it off the top/bottom walls and paddles, detects goals, and runs the serve delay between points.
- Sits between the frame timing generator and the renderer/score logic.

Parameters:
SCREEN_W, 640, visible width in pixels
SCREEN_H, 480, visible height in pixels
BALL_SIZE, 8, ball edge length in pixels (square)
SPEED_X, 2, horizontal step per frame in pixels
SPEED_Y, 1, vertical step per frame in pixels
SERVE_FRAMES, 60, frames the ball waits centred before moving
HOLDOFF_FRAMES, 4, frames after a paddle bounce during which paddle collisions are ignored

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
frame_tick_i  input  1  one-cycle pulse at start of vertical blank
collision_l_i  input  1  ball/left-paddle overlap, level, from sprite_collision
collision_r_i  input  1  ball/right-paddle overlap, level, from sprite_collision
ball_o  sprite_if  -  ball sprite: x_pos/y_pos (X_POS_W/Y_POS_W), right = x_pos+BALL_SIZE, bottom = y_pos+BALL_SIZE
score_l_o  output  1  one-cycle pulse: left player scored
score_r_o  output  1  one-cycle pulse: right player scored
in_play_o  output  1  high while state is PLAY

Behaviour:
- Single clock domain. All registers reset synchronously on rst_i; reset takes priority over every other input, including mid-serve or mid-play.
- Reset values:
  - x_pos = (SCREEN_W-BALL_SIZE)/2 = 316; y_pos = (SCREEN_H-BALL_SIZE)/2 = 236.
  - dir_x = +1 (right); dir_y = +1 (down).
  - state = SERVE; serve_cnt = 0; holdoff = 0.
  - hit_l = hit_r = 0; score_l_o = score_r_o = 0; in_play_o = 0.
- right/bottom on ball_o are registered together with x_pos/y_pos, so all four fields update in the same cycle.
- Collision latching:
  - Between frame ticks, hit_l is set when collision_l_i = 1 and hit_r is set when collision_r_i = 1. Both are sticky.
  - Both are cleared on the cycle frame_tick_i is processed. A collision asserted on that same cycle is dropped.
  - Latching runs in every state.
- State SERVE:
  - Ball is held at the centre position.
  - On each frame_tick_i, serve_cnt increments.
  - When serve_cnt = SERVE_FRAMES-1 on a tick: serve_cnt <= 0, state <= PLAY. Movement starts on the next tick.
- State PLAY: on frame_tick_i, apply these steps in order using the pre-tick values.
  1. holdoff != 0: decrement holdoff, ignore hit_l/hit_r.
  2. Otherwise, paddle bounces:
     - hit_l and dir_x = -1: dir_x <= +1, holdoff <= HOLDOFF_FRAMES.
     - hit_r and dir_x = +1: dir_x <= -1, holdoff <= HOLDOFF_FRAMES.
     - A hit against the current travel direction is ignored.
     - Both hits set: only the one matching dir_x is applied.
  3. Vertical:
     - dir_y = -1 and y_pos < SPEED_Y: y_pos <= 0, dir_y <= +1.
     - dir_y = +1 and y_pos+SPEED_Y > SCREEN_H-BALL_SIZE: y_pos <= SCREEN_H-BALL_SIZE, dir_y <= -1.
     - Otherwise: y_pos += dir_y*SPEED_Y.
  4. Horizontal, using the updated dir_x:
     - Moving left with x_pos < SPEED_X: goal for the right player; score_r_o pulses the next cycle.
     - Moving right with x_pos+SPEED_X > SCREEN_W-BALL_SIZE: goal for the left player; score_l_o pulses the next cycle.
     - Otherwise: x_pos += dir_x*SPEED_X.
     - x arithmetic must never wrap below 0 or exceed the X_POS_W range.
- State GOAL (entered from a goal in PLAY, lasts exactly 1 cycle):
  - The corresponding score pulse is high for this cycle only.
  - Ball recentred; serve_cnt <= 0; holdoff <= 0.
  - dir_x points toward the player who conceded; dir_y is kept.
  - Next state: SERVE.
  - A frame_tick_i arriving on this cycle is ignored.
- in_play_o = (state == PLAY), registered.
- Ticks are processed only in the state the block holds when the tick arrives. Only one tick is acted on per cycle.

Test Plan:
- Reset, then 59 ticks -> ball at (316,236), in_play_o = 0. 60th tick -> in_play_o = 1. Next tick -> x = 318, y = 237.
- In PLAY moving right, hold collision_r_i high for 3 cycles between ticks -> next tick dir_x = -1 and x decreases by 2. Re-assert collision_r_i within the next 4 frames -> no reversal.
- y = 471 moving down, SPEED_Y = 1 -> tick gives y = 472 and dir_y still +1. Next tick -> y = 472, dir_y = -1. Mirror case at the top: y = 0, dir_y = +1.
- Ball moving left at x = 1, no hit -> score_r_o high exactly one cycle, ball at (316,236), dir_x = -1, in SERVE. Serve lasts another 60 ticks.
- collision_l_i and collision_r_i both latched while moving left -> only the left bounce applies (dir_x = +1). collision_l_i on the tick cycle only -> ignored.
- Assert rst_i mid-PLAY at x = 500 together with frame_tick_i -> next cycle: all reset values, no score pulse.
